// File: rtl/axi_lite_reg_slave_pkg.sv
// ============================================================================
//  Module      : axi_lite_reg_slave_pkg
//  Description : Shared AXI4-lite widths, response codes, FSM encodings and
//                the byte-strobe merge helper for the register slave.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_lite_reg_slave_pkg;

    localparam int c_axi_addr_width = 32;
    localparam int c_axi_data_width = 32;
    localparam int c_axi_strb_width = c_axi_data_width / 8;

    localparam logic [1:0] c_axi_resp_okay   = 2'b00;
    localparam logic [1:0] c_axi_resp_slverr = 2'b10;

    localparam logic [1:0] c_wr_idle = 2'd0;
    localparam logic [1:0] c_wr_addr = 2'd1;
    localparam logic [1:0] c_wr_data = 2'd2;
    localparam logic [1:0] c_wr_resp = 2'd3;

    localparam logic [0:0] c_rd_idle = 1'b0;
    localparam logic [0:0] c_rd_data = 1'b1;

    // Replace only the bytes whose strobe bit is set.
    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] w_merged;
        w_merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                w_merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return w_merged;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_lite_addr_chk.sv
// ============================================================================
//  Module      : axi_lite_addr_chk
//  Description : Combinational byte-address decode into a register index plus
//                an aligned/in-range valid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_addr_chk #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    IDX_WIDTH  = $clog2(NUM_REGS)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [IDX_WIDTH-1:0]  idx,
    output logic                  valid
);

    localparam logic [ADDR_WIDTH-1:0] c_span = ADDR_WIDTH'(4 * NUM_REGS);

    logic [ADDR_WIDTH-1:0] w_offset;

    // The offset wraps below BASE_ADDR, so the lower bound is checked separately.
    assign w_offset = addr - BASE_ADDR;
    assign idx      = w_offset[IDX_WIDTH+1:2];
    assign valid    = (addr[1:0] == 2'b00) && (addr >= BASE_ADDR) && (w_offset < c_span);

endmodule

`default_nettype wire

// File: rtl/axi_lite_reg_slave.sv
// ============================================================================
//  Module      : axi_lite_reg_slave
//  Description : AXI4-lite register slave with byte-strobe writes, read-only
//                ID register 0, SLVERR on bad addresses, flat register bus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_reg_slave
    import axi_lite_reg_slave_pkg::*;
#(
    parameter int                        AXI_ADDR_WIDTH = c_axi_addr_width,
    parameter int                        AXI_DATA_WIDTH = c_axi_data_width,
    parameter int                        AXI_STRB_WIDTH = c_axi_strb_width,
    parameter int                        NUM_REGS       = 16,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter logic [AXI_DATA_WIDTH-1:0] ID_VALUE       = 32'h4B52_5600
) (
    input  logic                               ACLK,
    input  logic                               ARESETn,
    input  logic                               AWVALID,
    output logic                               AWREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                         AWPROT,
    input  logic                               WVALID,
    output logic                               WREADY,
    input  logic [AXI_DATA_WIDTH-1:0]          WDATA,
    input  logic [AXI_STRB_WIDTH-1:0]          WSTRB,
    output logic                               BVALID,
    input  logic                               BREADY,
    output logic [1:0]                         BRESP,
    input  logic                               ARVALID,
    output logic                               ARREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                         ARPROT,
    output logic                               RVALID,
    input  logic                               RREADY,
    output logic [AXI_DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                         RRESP,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]                reg_wr
);

    localparam int c_idx_w = $clog2(NUM_REGS);

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    logic [1:0]                r_wr_state;
    logic                      r_awready;
    logic                      r_wready;
    logic                      r_bvalid;
    logic [1:0]                r_bresp;
    logic [AXI_ADDR_WIDTH-1:0] r_aw_addr;
    logic [AXI_DATA_WIDTH-1:0] r_w_data;
    logic [AXI_STRB_WIDTH-1:0] r_w_strb;
    logic [NUM_REGS-1:0]       r_reg_wr;

    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_commit;
    logic [AXI_ADDR_WIDTH-1:0] w_commit_addr;
    logic [AXI_DATA_WIDTH-1:0] w_commit_data;
    logic [AXI_STRB_WIDTH-1:0] w_commit_strb;
    logic [c_idx_w-1:0]        w_wr_idx;
    logic                      w_wr_valid;
    logic                      w_wr_ok;

    // ------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------
    logic [0:0]                r_rd_state;
    logic                      r_arready;
    logic                      r_rvalid;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                r_rresp;
    logic [c_idx_w-1:0]        w_rd_idx;
    logic                      w_rd_valid;

    logic [AXI_DATA_WIDTH-1:0] w_reg_arr [NUM_REGS];
    logic                      w_unused;

    assign w_unused = ^{AWPROT, ARPROT};

    assign w_aw_hs = AWVALID && r_awready;
    assign w_w_hs  = WVALID && r_wready;

    // Whichever half arrived first was latched; the other comes straight off the bus.
    assign w_commit_addr = (r_wr_state == c_wr_addr) ? r_aw_addr : AWADDR;
    assign w_commit_data = (r_wr_state == c_wr_data) ? r_w_data  : WDATA;
    assign w_commit_strb = (r_wr_state == c_wr_data) ? r_w_strb  : WSTRB;

    always_comb begin
        w_commit = 1'b0;
        case (r_wr_state)
            c_wr_idle: w_commit = w_aw_hs && w_w_hs;
            c_wr_addr: w_commit = w_w_hs;
            c_wr_data: w_commit = w_aw_hs;
            default:   w_commit = 1'b0;
        endcase
    end

    axi_lite_addr_chk #(
        .ADDR_WIDTH (AXI_ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_WIDTH  (c_idx_w)
    ) u_wr_chk (
        .addr  (w_commit_addr),
        .idx   (w_wr_idx),
        .valid (w_wr_valid)
    );

    axi_lite_addr_chk #(
        .ADDR_WIDTH (AXI_ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_WIDTH  (c_idx_w)
    ) u_rd_chk (
        .addr  (ARADDR),
        .idx   (w_rd_idx),
        .valid (w_rd_valid)
    );

    // Register 0 is the read-only ID word.
    assign w_wr_ok = w_wr_valid && (w_wr_idx != '0);

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_wr_state <= c_wr_idle;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= c_axi_resp_okay;
            r_aw_addr  <= '0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_reg_wr   <= '0;
        end else begin
            r_reg_wr <= '0;
            case (r_wr_state)
                c_wr_idle: begin
                    if (w_commit) begin
                        r_wr_state <= c_wr_resp;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b0;
                    end else if (w_aw_hs) begin
                        r_wr_state <= c_wr_addr;
                        r_aw_addr  <= AWADDR;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b1;
                    end else if (w_w_hs) begin
                        r_wr_state <= c_wr_data;
                        r_w_data   <= WDATA;
                        r_w_strb   <= WSTRB;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b0;
                    end else begin
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                    end
                end
                c_wr_addr: begin
                    if (w_commit) begin
                        r_wr_state <= c_wr_resp;
                        r_wready   <= 1'b0;
                    end
                end
                c_wr_data: begin
                    if (w_commit) begin
                        r_wr_state <= c_wr_resp;
                        r_awready  <= 1'b0;
                    end
                end
                c_wr_resp: begin
                    if (BREADY) begin
                        r_wr_state <= c_wr_idle;
                        r_bvalid   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                    end
                end
                default: begin
                    r_wr_state <= c_wr_idle;
                    r_awready  <= 1'b0;
                    r_wready   <= 1'b0;
                    r_bvalid   <= 1'b0;
                end
            endcase

            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? c_axi_resp_okay : c_axi_resp_slverr;
                if (w_wr_ok) begin
                    r_reg_wr <= NUM_REGS'(1) << w_wr_idx;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file (slot 0 is the constant ID)
    // ------------------------------------------------------------------
    assign w_reg_arr[0] = ID_VALUE;

    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
        localparam logic [c_idx_w-1:0] c_my_idx = c_idx_w'(gi);
        logic [AXI_DATA_WIDTH-1:0] r_value;

        always_ff @(posedge ACLK) begin
            if (!ARESETn) begin
                r_value <= '0;
            end else if (w_commit && w_wr_ok && (w_wr_idx == c_my_idx)) begin
                r_value <= strb_merge(r_value, w_commit_data, w_commit_strb);
            end
        end

        assign w_reg_arr[gi] = r_value;
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign reg_q[AXI_DATA_WIDTH*gi +: AXI_DATA_WIDTH] = w_reg_arr[gi];
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_rd_state <= c_rd_idle;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= c_axi_resp_okay;
        end else begin
            case (r_rd_state)
                c_rd_idle: begin
                    if (ARVALID && r_arready) begin
                        r_rd_state <= c_rd_data;
                        r_arready  <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rdata    <= w_rd_valid ? w_reg_arr[w_rd_idx] : '0;
                        r_rresp    <= w_rd_valid ? c_axi_resp_okay : c_axi_resp_slverr;
                    end else begin
                        r_arready  <= 1'b1;
                    end
                end
                c_rd_data: begin
                    if (RREADY) begin
                        r_rd_state <= c_rd_idle;
                        r_rvalid   <= 1'b0;
                        r_arready  <= 1'b1;
                    end
                end
                default: begin
                    r_rd_state <= c_rd_idle;
                    r_arready  <= 1'b0;
                    r_rvalid   <= 1'b0;
                end
            endcase
        end
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;
    assign reg_wr  = r_reg_wr;

endmodule

`default_nettype wire
